// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the bundle of pipeline-control outputs and its canned
// values, and a small helper for sizing the sequence counter.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    // Code 3 is never entered. It decodes as RUN and always returns to RUN.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RSVD  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector. Purely combinational: flags when the load in
// EX writes a register that the instruction in ID reads.
// Ports:
//   id_rs_i        rs of the instruction in ID
//   id_rt_i        rt of the instruction in ID
//   id_uses_rt_i   ID instruction actually reads rt
//   ex_rd_i        destination register of the instruction in EX
//   ex_mem_read_i  EX instruction is a load
//   hazard_o       load-use hazard present
module pipeline_hazard_ctrl_hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    output logic                  hazard_o
);

    logic rd_nonzero;
    logic rs_match;
    logic rt_match;

    // A load into r0 is discarded by the register file, so it can never
    // feed a dependent instruction.
    assign rd_nonzero = (ex_rd_i != '0);
    assign rs_match   = (ex_rd_i == id_rs_i);
    assign rt_match   = id_uses_rt_i && (ex_rd_i == id_rt_i);
    assign hazard_o   = ex_mem_read_i && rd_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage pipeline. Stalls PC and IF/ID
// with ID/EX bubbles on load-use hazards, squashes wrong-path fetches on a
// taken branch or jump, and counts stalled cycles for the debug display.
// All control outputs respond in the same cycle the condition is seen.
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   id_rs, id_rt     source registers of the ID instruction
//   id_uses_rt       ID instruction reads rt
//   ex_rd            destination of the EX instruction
//   ex_mem_read      EX instruction is a load
//   ex_branch_taken  branch in EX resolved taken
//   ex_jump          jump in EX
//   pc_write         PC may update
//   ifid_write       IF/ID may load
//   ifid_flush       IF/ID loads a NOP
//   idex_bubble      ID/EX control fields forced to zero
//   ctrl_state       current FSM state (debug)
//   stall_cycles     saturating count of cycles with pc_write low
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W        = REG_ADDR_W_DEF,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned PERF_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_jump,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            ctrl_state,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int unsigned CNT_W = $clog2(max_u(LOAD_STALL_CYCLES, FLUSH_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PERF_W-1:0] PERF_ONE    = PERF_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX    = {PERF_W{1'b1}};

    // Single-cycle sequences need no extra state: they complete in RUN.
    localparam ctrl_state_e STALL_NEXT = (LOAD_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
    localparam ctrl_state_e FLUSH_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_q;
    pipe_ctrl_t        ctrl;
    pipe_ctrl_t        ctrl_out;
    logic              hazard;
    logic              redirect;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .hazard_o      (hazard)
    );

    assign redirect = ex_branch_taken || ex_jump;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_RUN;
        case (state_q)
            ST_STALL: begin
                if (redirect) begin
                    ctrl    = CTRL_FLUSH;
                    state_d = FLUSH_NEXT;
                    cnt_d   = FLUSH_RELOAD;
                end else begin
                    ctrl    = CTRL_STALL;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? ST_RUN : ST_STALL;
                end
            end
            ST_FLUSH: begin
                ctrl = CTRL_FLUSH;
                if (redirect) begin
                    // A fresh redirect restarts the squash window.
                    state_d = FLUSH_NEXT;
                    cnt_d   = FLUSH_RELOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? ST_RUN : ST_FLUSH;
                end
            end
            default: begin
                // RUN, and the unused code which behaves as RUN.
                if (redirect) begin
                    // Redirect wins: the stalled ID instruction is wrong-path anyway.
                    ctrl    = CTRL_FLUSH;
                    state_d = FLUSH_NEXT;
                    cnt_d   = FLUSH_RELOAD;
                end else if (hazard) begin
                    ctrl    = CTRL_STALL;
                    state_d = STALL_NEXT;
                    cnt_d   = STALL_RELOAD;
                end else begin
                    state_d = ST_RUN;
                end
                if (state_q == ST_RSVD) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!ctrl.pc_write && (stall_q != PERF_MAX)) begin
                stall_q <= stall_q + PERF_ONE;
            end
        end
    end

    // Reset holds the front end frozen and keeps bubbles flowing.
    assign ctrl_out     = reset ? CTRL_RESET : ctrl;
    assign pc_write     = ctrl_out.pc_write;
    assign ifid_write   = ctrl_out.ifid_write;
    assign ifid_flush   = ctrl_out.ifid_flush;
    assign idex_bubble  = ctrl_out.idex_bubble;
    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Three instances share stimulus:
//   dut_a  default parameters
//   dut_b  LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2
//   dut_c  PERF_W=4 (counter saturation)
// Outputs are packed as {pc_write, ifid_write, ifid_flush, idex_bubble}.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] O_RUN   = 32'b1100;
    localparam logic [31:0] O_STALL = 32'b0001;
    localparam logic [31:0] O_FLUSH = 32'b1111;
    localparam logic [31:0] O_RST   = 32'b0011;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_jump;

    logic        pcw_a, ifw_a, iff_a, bub_a;
    logic [1:0]  state_a;
    logic [15:0] stall_a;
    logic        pcw_b, ifw_b, iff_b, bub_b;
    logic [1:0]  state_b;
    logic [15:0] stall_b;
    logic        pcw_c, ifw_c, iff_c, bub_c;
    logic [1:0]  state_c;
    logic [3:0]  stall_c;

    logic [3:0] outs_a, outs_b, outs_c;
    assign outs_a = {pcw_a, ifw_a, iff_a, bub_a};
    assign outs_b = {pcw_b, ifw_b, iff_b, bub_b};
    assign outs_c = {pcw_c, ifw_c, iff_c, bub_c};

    int n_checks;
    int n_errors;

    pipeline_hazard_ctrl dut_a (
        .clk (clk), .reset (reset),
        .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
        .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
        .ex_branch_taken (ex_branch_taken), .ex_jump (ex_jump),
        .pc_write (pcw_a), .ifid_write (ifw_a), .ifid_flush (iff_a),
        .idex_bubble (bub_a), .ctrl_state (state_a), .stall_cycles (stall_a)
    );

    pipeline_hazard_ctrl #(
        .LOAD_STALL_CYCLES (3),
        .FLUSH_CYCLES      (2)
    ) dut_b (
        .clk (clk), .reset (reset),
        .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
        .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
        .ex_branch_taken (ex_branch_taken), .ex_jump (ex_jump),
        .pc_write (pcw_b), .ifid_write (ifw_b), .ifid_flush (iff_b),
        .idex_bubble (bub_b), .ctrl_state (state_b), .stall_cycles (stall_b)
    );

    pipeline_hazard_ctrl #(
        .PERF_W (4)
    ) dut_c (
        .clk (clk), .reset (reset),
        .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
        .ex_rd (ex_rd), .ex_mem_read (ex_mem_read),
        .ex_branch_taken (ex_branch_taken), .ex_jump (ex_jump),
        .pc_write (pcw_c), .ifid_write (ifw_c), .ifid_flush (iff_c),
        .idex_bubble (bub_c), .ctrl_state (state_c), .stall_cycles (stall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic [4:0] rd, input logic mem_rd, input logic br, input logic jmp);
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses_rt;
        ex_rd           = rd;
        ex_mem_read     = mem_rd;
        ex_branch_taken = br;
        ex_jump         = jmp;
    endtask

    // Advance past the next rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset state and forced outputs.
        #2;
        check("rst_outs", 32'(outs_a), O_RST);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_perf", 32'(stall_a), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("idle_outs", 32'(outs_a), O_RUN);

        // 1: load-use on rs, single bubble.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        check("t1_outs", 32'(outs_a), O_STALL);
        check("t1_state", 32'(state_a), 32'd0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t1_next_state", 32'(state_a), 32'd0);
        check("t1_next_outs", 32'(outs_a), O_RUN);
        check("t1_perf", 32'(stall_a), 32'd1);

        // 2: rt gating and register 0.
        drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("t2_rt_unused", 32'(outs_a), O_RUN);
        drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("t2_rt_used", 32'(outs_a), O_STALL);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("t2_r0", 32'(outs_a), O_RUN);
        tick();
        check("t2_perf", 32'(stall_a), 32'd1);

        // 3: redirect beats hazard; branch alone also flushes.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        #1;
        check("t3_jump_haz", 32'(outs_a), O_FLUSH);
        check("t3_state", 32'(state_a), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("t3_branch", 32'(outs_a), O_FLUSH);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t3_next_state", 32'(state_a), 32'd0);
        check("t3_perf", 32'(stall_a), 32'd1);

        // 4a: three-cycle stall.
        pulse_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        check("t4a_c0", 32'(outs_b), O_STALL);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t4a_c1_outs", 32'(outs_b), O_STALL);
        check("t4a_c1_state", 32'(state_b), 32'd1);
        tick();
        check("t4a_c2_outs", 32'(outs_b), O_STALL);
        check("t4a_c2_state", 32'(state_b), 32'd1);
        tick();
        check("t4a_c3_outs", 32'(outs_b), O_RUN);
        check("t4a_c3_state", 32'(state_b), 32'd0);
        check("t4a_perf", 32'(stall_b), 32'd3);

        // 4b: branch in the second stall cycle, re-redirect during FLUSH.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check("t4b_c1_outs", 32'(outs_b), O_FLUSH);
        check("t4b_c1_state", 32'(state_b), 32'd1);
        tick();
        #1;
        check("t4b_c2_outs", 32'(outs_b), O_FLUSH);
        check("t4b_c2_state", 32'(state_b), 32'd2);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t4b_c3_outs", 32'(outs_b), O_FLUSH);
        check("t4b_c3_state", 32'(state_b), 32'd2);
        tick();
        check("t4b_c4_outs", 32'(outs_b), O_RUN);
        check("t4b_c4_state", 32'(state_b), 32'd0);
        check("t4b_perf", 32'(stall_b), 32'd4);

        // 5: asynchronous reset in the middle of a stall.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t5_pre_state", 32'(state_b), 32'd1);
        check("t5_pre_perf", 32'(stall_b), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_outs", 32'(outs_b), O_RST);
        check("t5_rst_state", 32'(state_b), 32'd0);
        check("t5_rst_perf", 32'(stall_b), 32'd0);
        tick();
        check("t5_rst_hold", 32'(outs_b), O_RST);
        reset = 1'b0;
        #1;
        check("t5_rel_outs", 32'(outs_b), O_RUN);
        tick();
        check("t5_after_state", 32'(state_b), 32'd0);
        check("t5_after_perf", 32'(stall_b), 32'd0);

        // 6: stall counter saturation on a 4-bit counter.
        drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        check("t6_c_mid", 32'(stall_c), 32'd10);
        repeat (10) tick();
        check("t6_c_sat", 32'(stall_c), 32'd15);
        check("t6_a_wide", 32'(stall_a), 32'd20);
        check("t6_c_outs", 32'(outs_c), O_STALL);
        check("t6_c_state", 32'(state_c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
